// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle controller: phase sequencer with per-phase timer, rinse repeat,
// program modes, pause/resume and abort-with-drain.
module wm_cycle_ctrl #(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned FILL_T    = 4,
   parameter int unsigned WASH_T    = 10,
   parameter int unsigned DRAIN_T   = 3,
   parameter int unsigned RINSE_T   = 6,
   parameter int unsigned RINSE_CNT = 2,
   parameter int unsigned SPIN_T    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_button,
   input  logic             pause_button,
   input  logic             abort,
   input  logic [1:0]       mode,
   output logic [2:0]       state,
   output logic             out,
   output logic             done,
   output logic             paused,
   output logic [CNT_W-1:0] rinse_left
);

   typedef enum logic [2:0] {
      StOff   = 3'b000,
      StFill  = 3'b001,
      StWash  = 3'b010,
      StDrain = 3'b011,
      StRinse = 3'b100,
      StSpin  = 3'b101,
      StDone  = 3'b110
   } state_e;

   localparam int unsigned WashQuickT = ((WASH_T >> 1) == 0) ? 1 : (WASH_T >> 1);

   localparam logic [CNT_W-1:0] FillLast      = CNT_W'(FILL_T - 1);
   localparam logic [CNT_W-1:0] WashLast      = CNT_W'(WASH_T - 1);
   localparam logic [CNT_W-1:0] WashQuickLast = CNT_W'(WashQuickT - 1);
   localparam logic [CNT_W-1:0] DrainLast     = CNT_W'(DRAIN_T - 1);
   localparam logic [CNT_W-1:0] RinseLast     = CNT_W'(RINSE_T - 1);
   localparam logic [CNT_W-1:0] SpinLast      = CNT_W'(SPIN_T - 1);
   localparam logic [CNT_W-1:0] One           = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] rinse_q, rinse_d;
   logic [1:0]       mode_q, mode_d;
   logic             armed_q, armed_d;
   logic             abort_q, abort_d;
   logic             paused_d;
   logic [CNT_W-1:0] phase_last;
   logic             phase_end;

   always_comb begin
      phase_last = '0;
      case (state_q)
         StFill:  phase_last = FillLast;
         StWash:  phase_last = (mode_q == 2'b01) ? WashQuickLast : WashLast;
         StDrain: phase_last = DrainLast;
         StRinse: phase_last = RinseLast;
         StSpin:  phase_last = SpinLast;
         default: phase_last = '0;
      endcase
      phase_end = (timer_q == phase_last);
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q + One;
      rinse_d  = rinse_q;
      mode_d   = mode_q;
      armed_d  = armed_q;
      abort_d  = abort_q;
      paused_d = 1'b0;

      case (state_q)
         StOff: begin
            timer_d = '0;
            abort_d = 1'b0;
            if (!start_button) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               mode_d = mode;
               case (mode)
                  2'b00: begin
                     rinse_d = CNT_W'(RINSE_CNT);
                     state_d = StFill;
                  end
                  2'b01: begin
                     rinse_d = One;
                     state_d = StFill;
                  end
                  2'b10: begin
                     rinse_d = One;
                     state_d = StRinse;
                  end
                  default: begin
                     rinse_d = '0;
                     state_d = StSpin;
                  end
               endcase
            end
         end

         StFill, StWash, StRinse: begin
            if (abort) begin
               state_d = StDrain;
               timer_d = '0;
               abort_d = 1'b1;
            end else if (pause_button) begin
               timer_d  = timer_q;
               paused_d = 1'b1;
            end else if (phase_end) begin
               timer_d = '0;
               if (state_q == StFill) begin
                  state_d = StWash;
               end else if (state_q == StWash) begin
                  state_d = StDrain;
               end else if (rinse_q > One) begin
                  rinse_d = rinse_q - One;
               end else begin
                  state_d = StSpin;
               end
            end
         end

         StDrain: begin
            // Abort during Drain only marks the run; the drain itself must finish.
            if (abort) begin
               abort_d = 1'b1;
            end
            if (pause_button && !abort) begin
               timer_d  = timer_q;
               paused_d = 1'b1;
            end else if (phase_end) begin
               timer_d = '0;
               state_d = (abort_q || abort) ? StDone : StRinse;
            end
         end

         StSpin: begin
            if (abort) begin
               state_d = StDone;
               timer_d = '0;
            end else if (pause_button) begin
               timer_d  = timer_q;
               paused_d = 1'b1;
            end else if (phase_end) begin
               state_d = StDone;
               timer_d = '0;
            end
         end

         StDone: begin
            timer_d = '0;
            state_d = StOff;
         end

         default: begin
            timer_d = '0;
            state_d = StOff;
         end
      endcase

      // Disarm on Done entry so a held start cannot relaunch a program.
      if (state_d == StDone) begin
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StOff;
         timer_q <= '0;
         rinse_q <= '0;
         mode_q  <= 2'b00;
         armed_q <= 1'b1;
         abort_q <= 1'b0;
         out     <= 1'b0;
         done    <= 1'b0;
         paused  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rinse_q <= rinse_d;
         mode_q  <= mode_d;
         armed_q <= armed_d;
         abort_q <= abort_d;
         out     <= (state_d != StOff) && (state_d != StDone) && !paused_d;
         done    <= (state_d == StDone);
         paused  <= paused_d;
      end
   end

   assign state      = state_q;
   assign rinse_left = rinse_q;

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Directed bench for wm_cycle_ctrl: scenario table with hand-computed phase lengths,
// plus hand-written sequences for reset, idle-input and mid-run reset corners.
module tb_wm_cycle_ctrl;

   localparam logic [2:0] S_OFF   = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_WASH  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_RINSE = 3'd4;
   localparam logic [2:0] S_SPIN  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic       clk_tb = 1'b0;
   logic       rst_n;
   logic       start_b;
   logic       pause_b;
   logic       abort_b;
   logic [1:0] md;
   logic [2:0] st;
   logic       out_o;
   logic       done_o;
   logic       paused_o;
   logic [7:0] rl;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_tb = ~clk_tb;

   wm_cycle_ctrl #(
      .CNT_W    (8),
      .FILL_T   (4),
      .WASH_T   (10),
      .DRAIN_T  (3),
      .RINSE_T  (6),
      .RINSE_CNT(2),
      .SPIN_T   (8)
   ) dut (
      .clk         (clk_tb),
      .reset       (rst_n),
      .start_button(start_b),
      .pause_button(pause_b),
      .abort       (abort_b),
      .mode        (md),
      .state       (st),
      .out         (out_o),
      .done        (done_o),
      .paused      (paused_o),
      .rinse_left  (rl)
   );

   // Edge k counts rising edges from E0, the first edge that samples start=1.
   typedef struct {
      logic [1:0] mode;
      int         pause_at;
      int         pause_len;
      int         abort_at;
      int         exp_done;
      int         exp_fill;
      int         exp_wash;
      int         exp_drain;
      int         exp_rinse;
      int         exp_spin;
      int         exp_load;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit legal(input logic [2:0] p, input logic [2:0] c);
      if (p == c) return 1'b1;
      case (p)
         S_OFF:   return (c == S_FILL) || (c == S_RINSE) || (c == S_SPIN);
         S_FILL:  return (c == S_WASH) || (c == S_DRAIN);
         S_WASH:  return (c == S_DRAIN);
         S_DRAIN: return (c == S_RINSE) || (c == S_DONE);
         S_RINSE: return (c == S_DRAIN) || (c == S_SPIN);
         S_SPIN:  return (c == S_DONE);
         S_DONE:  return (c == S_OFF);
         default: return 1'b0;
      endcase
   endfunction

   task automatic run_scenario(input int idx, input vec_t v);
      int         cnt[7];
      int         done_edge  = -1;
      int         done_hi    = 0;
      int         last_rinse = -1;
      int         limit;
      logic [2:0] prev = S_OFF;
      logic [2:0] cur;
      logic       exp_p;
      string      tag;
      tag   = $sformatf("s%0d", idx);
      limit = v.exp_done + 4;
      for (int i = 0; i < 7; i++) cnt[i] = 0;
      for (int k = 0; k <= limit; k++) begin
         @(negedge clk_tb);
         start_b = 1'b1;
         md      = v.mode;
         exp_p   = (k >= v.pause_at) && (k < v.pause_at + v.pause_len);
         pause_b = exp_p;
         abort_b = (k == v.abort_at);
         @(posedge clk_tb);
         #1;
         cur = st;
         if (cur < 3'd7) cnt[cur]++;
         if (k == 0) check({tag, " rinse_load"}, rl, v.exp_load);
         check({tag, " legal_transition"}, legal(prev, cur), 1);
         check({tag, " paused"}, paused_o, exp_p);
         check({tag, " out"}, out_o, (cur != S_OFF) && (cur != S_DONE) && !exp_p);
         if (done_o) done_hi++;
         if (cur == S_DONE && done_edge < 0) done_edge = k;
         if (cur == S_RINSE) last_rinse = int'(rl);
         prev = cur;
      end
      check({tag, " done_edge"}, done_edge, v.exp_done);
      check({tag, " fill_cycles"}, cnt[S_FILL], v.exp_fill);
      check({tag, " wash_cycles"}, cnt[S_WASH], v.exp_wash);
      check({tag, " drain_cycles"}, cnt[S_DRAIN], v.exp_drain);
      check({tag, " rinse_cycles"}, cnt[S_RINSE], v.exp_rinse);
      check({tag, " spin_cycles"}, cnt[S_SPIN], v.exp_spin);
      check({tag, " done_state_cycles"}, cnt[S_DONE], 1);
      check({tag, " done_pulse_cycles"}, done_hi, 1);
      check({tag, " no_restart_held_start"}, cur, S_OFF);
      if (v.exp_rinse > 0) check({tag, " last_rinse_left"}, last_rinse, 1);
      @(negedge clk_tb);
      start_b = 1'b0;
      pause_b = 1'b0;
      abort_b = 1'b0;
      @(posedge clk_tb);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      start_b = 1'b0;
      pause_b = 1'b0;
      abort_b = 1'b0;
      md      = 2'b00;

      //         mode   p_at p_len ab_at done fill wash drn rns spin load
      vecs[0] = '{2'b00, -1, 0, -1, 37, 4, 10, 3, 12, 8, 2};
      vecs[1] = '{2'b01, -1, 0, -1, 26, 4,  5, 3,  6, 8, 1};
      vecs[2] = '{2'b00,  6, 5, -1, 42, 4, 15, 3, 12, 8, 2};
      vecs[3] = '{2'b00, -1, 0,  8, 11, 4,  4, 3,  0, 0, 2};
      vecs[4] = '{2'b11, -1, 0, -1,  8, 0,  0, 0,  0, 8, 0};
      vecs[5] = '{2'b11, -1, 0,  3,  3, 0,  0, 0,  0, 3, 0};
      vecs[6] = '{2'b10, -1, 0, -1, 14, 0,  0, 0,  6, 8, 1};
      vecs[7] = '{2'b10, -1, 0,  2,  5, 0,  0, 3,  2, 0, 1};
      vecs[8] = '{2'b00, -1, 0, 15, 17, 4, 10, 3,  0, 0, 2};
      vecs[9] = '{2'b00, -1, 0,  1,  4, 1,  0, 3,  0, 0, 2};

      repeat (2) @(posedge clk_tb);
      #1;
      check("reset state", st, S_OFF);
      check("reset out", out_o, 0);
      check("reset done", done_o, 0);
      check("reset paused", paused_o, 0);
      check("reset rinse_left", rl, 0);

      // Pause and abort in Off must have no effect.
      @(negedge clk_tb);
      rst_n   = 1'b1;
      pause_b = 1'b1;
      abort_b = 1'b1;
      @(posedge clk_tb);
      #1;
      check("off_ignore state", st, S_OFF);
      check("off_ignore paused", paused_o, 0);
      check("off_ignore out", out_o, 0);
      @(negedge clk_tb);
      pause_b = 1'b0;
      abort_b = 1'b0;
      @(posedge clk_tb);
      #1;

      for (int i = 0; i < 10; i++) run_scenario(i, vecs[i]);

      // Reset in the first Rinse pass of a full program.
      @(negedge clk_tb);
      start_b = 1'b1;
      md      = 2'b00;
      repeat (20) @(posedge clk_tb);
      #1;
      check("mid_rinse state", st, S_RINSE);
      check("mid_rinse rinse_left", rl, 2);
      @(negedge clk_tb);
      rst_n   = 1'b0;
      start_b = 1'b0;
      @(posedge clk_tb);
      #1;
      check("mid_reset state", st, S_OFF);
      check("mid_reset out", out_o, 0);
      check("mid_reset done", done_o, 0);
      check("mid_reset paused", paused_o, 0);
      check("mid_reset rinse_left", rl, 0);
      @(negedge clk_tb);
      rst_n   = 1'b1;
      start_b = 1'b1;
      md      = 2'b11;
      @(posedge clk_tb);
      #1;
      check("post_reset restart state", st, S_SPIN);
      check("post_reset restart out", out_o, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
